// File: rtl/bcd_counter_chain_pkg.sv
// rtl/bcd_counter_chain_pkg.sv - legal-range checks shared by the modulo counters
// Contents:
//   MAX_DIGITS      largest supported cascade length
//   digits_legal    true when a digit count is within 1..MAX_DIGITS
//   modulus_legal   true when a modulus fits 2..2^digit_w
package bcd_counter_chain_pkg;

    localparam int MAX_DIGITS = 8;

    function automatic bit digits_legal(input int digits);
        return (digits >= 1) && (digits <= MAX_DIGITS);
    endfunction

    function automatic bit modulus_legal(input int modulus, input int digit_w);
        return (digit_w >= 1) && (digit_w <= 30) &&
               (modulus >= 2) && (modulus <= (1 << digit_w));
    endfunction

endpackage

// File: rtl/mod_digit.sv
// rtl/mod_digit.sv - one modulo-MODULUS up/down digit with clear, clamped load and step
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset, q -> 0
//   clr       synchronous clear (highest priority)
//   load      synchronous load of load_val, clamped to MODULUS-1
//   load_val  value to load
//   step      advance one count in direction up_dn (lowest priority)
//   up_dn     1 = count up, 0 = count down
//   q         registered digit value
//   tc        digit sits at its terminal value for the current direction
module mod_digit
    import bcd_counter_chain_pkg::*;
#(
    parameter int DIGIT_W = 4,
    parameter int MODULUS = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               step,
    input  logic               up_dn,
    output logic [DIGIT_W-1:0] q,
    output logic               tc
);

    generate
        if (!modulus_legal(MODULUS, DIGIT_W)) begin : g_bad_modulus
            $error("mod_digit: MODULUS must be in 2..2**DIGIT_W");
        end
    endgenerate

    localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(MODULUS - 1);

    logic [DIGIT_W-1:0] load_clamped;
    logic [DIGIT_W-1:0] q_stepped;

    always_comb begin
        // Comparing against MODULUS-1 rather than MODULUS keeps the compare
        // within DIGIT_W bits even when MODULUS == 2**DIGIT_W.
        load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

        if (up_dn) begin
            q_stepped = (q == MAX_VAL) ? '0 : q + DIGIT_W'(1);
        end else begin
            q_stepped = (q == '0) ? MAX_VAL : q - DIGIT_W'(1);
        end

        tc = up_dn ? (q == MAX_VAL) : (q == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= load_clamped;
        end else if (step) begin
            q <= q_stepped;
        end
    end

endmodule

// File: rtl/bcd_counter_chain.sv
// rtl/bcd_counter_chain.sv - cascadable multi-digit modulo up/down counter
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   clr       synchronous clear of all digits (priority over load and en)
//   load      synchronous parallel load (priority over en)
//   load_val  load value, digit i at [i*DIGIT_W +: DIGIT_W], digit 0 least significant
//   en        count enable
//   up_dn     1 = up, 0 = down
//   cnt       registered count, same packing as load_val
//   digit_tc  per-digit terminal flags (combinational)
//   cout      en & all digits terminal; drives the en of a following chain
//   wrapped   one-cycle registered pulse in the cycle cnt shows the wrapped value
module bcd_counter_chain
    import bcd_counter_chain_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4,
    parameter int MODULUS = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      load,
    input  logic [DIGITS*DIGIT_W-1:0] load_val,
    input  logic                      en,
    input  logic                      up_dn,
    output logic [DIGITS*DIGIT_W-1:0] cnt,
    output logic [DIGITS-1:0]         digit_tc,
    output logic                      cout,
    output logic                      wrapped
);

    generate
        if (!digits_legal(DIGITS)) begin : g_bad_digits
            $error("bcd_counter_chain: DIGITS must be in 1..8");
        end
        if (!modulus_legal(MODULUS, DIGIT_W)) begin : g_bad_modulus
            $error("bcd_counter_chain: MODULUS must be in 2..2**DIGIT_W");
        end
    endgenerate

    // carry[i] is the step enable of digit i: en ANDed with the terminal
    // flags of every lower digit. carry[DIGITS] is the chain carry/borrow.
    logic [DIGITS:0] carry;

    assign carry[0] = en;

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            mod_digit #(
                .DIGIT_W (DIGIT_W),
                .MODULUS (MODULUS)
            ) u_digit (
                .clk      (clk),
                .reset    (reset),
                .clr      (clr),
                .load     (load),
                .load_val (load_val[i*DIGIT_W +: DIGIT_W]),
                .step     (carry[i]),
                .up_dn    (up_dn),
                .q        (cnt[i*DIGIT_W +: DIGIT_W]),
                .tc       (digit_tc[i])
            );

            assign carry[i+1] = carry[i] & digit_tc[i];
        end
    endgenerate

    assign cout = carry[DIGITS];

    // A rollover only counts when the edge actually stepped the chain; clr or
    // load on the same edge overrides the step, so no wrap is reported.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrapped <= 1'b0;
        end else begin
            wrapped <= cout & ~clr & ~load;
        end
    end

endmodule

// File: tb/tb_bcd_counter_chain.sv
// tb/tb_bcd_counter_chain.sv - self-checking bench for bcd_counter_chain
module tb_bcd_counter_chain;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic        en = 1'b0;
    logic        up_dn = 1'b1;
    logic [15:0] cnt;
    logic [3:0]  digit_tc;
    logic        cout;
    logic        wrapped;

    logic        clr16 = 1'b0;
    logic        load16 = 1'b0;
    logic [15:0] load_val16 = '0;
    logic        en16 = 1'b0;
    logic        up_dn16 = 1'b1;
    logic [15:0] cnt16;
    logic [3:0]  digit_tc16;
    logic        cout16;
    logic        wrapped16;

    int cmp_count = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    bcd_counter_chain #(.DIGITS(4), .DIGIT_W(4), .MODULUS(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .up_dn    (up_dn),
        .cnt      (cnt),
        .digit_tc (digit_tc),
        .cout     (cout),
        .wrapped  (wrapped)
    );

    bcd_counter_chain #(.DIGITS(4), .DIGIT_W(4), .MODULUS(16)) dut16 (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr16),
        .load     (load16),
        .load_val (load_val16),
        .en       (en16),
        .up_dn    (up_dn16),
        .cnt      (cnt16),
        .digit_tc (digit_tc16),
        .cout     (cout16),
        .wrapped  (wrapped16)
    );

    typedef struct {
        logic        clr;
        logic        load;
        logic [15:0] lv;
        logic        en;
        logic        up;
        logic        exp_cout;
        logic [15:0] exp_cnt;
        logic        exp_wrapped;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic l, input logic [15:0] v,
                         input logic e, input logic u);
        clr = c;
        load = l;
        load_val = v;
        en = e;
        up_dn = u;
    endtask

    initial begin
        //            clr load lv       en up  cout cnt      wrapped
        vecs[0]  = '{1'b0, 1'b1, 16'h9998, 1'b0, 1'b1, 1'b0, 16'h9998, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h9999, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0999, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h9999, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 16'hFA3C, 1'b0, 1'b1, 1'b0, 16'h9939, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 16'h4321, 1'b0, 1'b1, 1'b0, 16'h4321, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 16'h0005, 1'b1, 1'b1, 1'b0, 16'h0005, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 16'h0009, 1'b0, 1'b1, 1'b0, 16'h0009, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0009, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 16'h0010, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0009, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b0, 16'h9999, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 16'h1111, 1'b1, 1'b1, 1'b1, 16'h1111, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b0, 16'h9999, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0};

        // Reset state
        #2;
        check("reset cnt", 32'(cnt), 32'h0);
        check("reset wrapped", 32'(wrapped), 32'h0);
        tick();
        check("reset hold cnt", 32'(cnt), 32'h0);
        reset = 1'b0;
        tick();

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].clr, vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].up);
            #1;
            check($sformatf("vec%0d cout", i), 32'(cout), 32'(vecs[i].exp_cout));
            tick();
            check($sformatf("vec%0d cnt", i), 32'(cnt), 32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d wrapped", i), 32'(wrapped), 32'(vecs[i].exp_wrapped));
        end

        // Wrapped is a single-cycle pulse: 9998 -> 9999 -> 0000 -> 0001
        drive(1'b0, 1'b1, 16'h9998, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        tick();
        tick();
        check("pulse wrapped hi", 32'(wrapped), 32'h1);
        tick();
        check("pulse wrapped lo", 32'(wrapped), 32'h0);

        // Terminal flags, en gating and direction flip
        drive(1'b0, 1'b1, 16'h0009, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        #1;
        check("tc at 0009 up", 32'(digit_tc), 32'h1);
        check("cout gated by en", 32'(cout), 32'h0);
        drive(1'b0, 1'b1, 16'h9999, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        #1;
        check("cout 9999 up", 32'(cout), 32'h1);
        up_dn = 1'b0;
        #1;
        check("cout 9999 flip down", 32'(cout), 32'h0);
        check("tc 9999 down", 32'(digit_tc), 32'h0);
        drive(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        #1;
        check("tc 0010 down", 32'(digit_tc), 32'hD);
        tick();
        check("flip 0010 -> 0009", 32'(cnt), 32'h0009);
        en = 1'b0;

        // Reset mid-count
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        repeat (357) tick();
        check("count to 0357", 32'(cnt), 32'h0357);
        #2;
        reset = 1'b1;
        #1;
        check("async reset cnt", 32'(cnt), 32'h0);
        check("async reset wrapped", 32'(wrapped), 32'h0);
        tick();
        check("reset held over edge", 32'(cnt), 32'h0);
        #2;
        reset = 1'b0;
        tick();
        check("first count after reset", 32'(cnt), 32'h0001);
        en = 1'b0;

        // MODULUS=16 build
        load16 = 1'b1;
        load_val16 = 16'hFA3C;
        tick();
        check("m16 no clamp", 32'(cnt16), 32'hFA3C);
        load_val16 = 16'hFFFF;
        tick();
        load16 = 1'b0;
        en16 = 1'b1;
        up_dn16 = 1'b1;
        #1;
        check("m16 cout at FFFF", 32'(cout16), 32'h1);
        tick();
        check("m16 rollover cnt", 32'(cnt16), 32'h0000);
        check("m16 rollover wrapped", 32'(wrapped16), 32'h1);
        up_dn16 = 1'b0;
        tick();
        check("m16 down borrow", 32'(cnt16), 32'hFFFF);
        en16 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule

// File: doc/bcd_counter_chain.md
Name: bcd_counter_chain

Overview:
- Parametrised, cascadable multi-digit modulo counter.
- Next generation of the single-digit decade counter: configurable digit count, digit width and modulus.
- Adds up/down counting, count enable, synchronous clear and parallel load.
- Used for time-base, event-count and display-drive counting, where each digit feeds a 7-seg or BCD consumer.

Parameters:
- DIGITS, 4, number of cascaded digits; legal range 1..8.
- DIGIT_W, 4, bits per digit.
- MODULUS, 10, count states per digit; legal range 2..2^DIGIT_W. Elaboration error if outside this range.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of all digits.
- load  in  1  synchronous parallel load.
- load_val  in  DIGITS*DIGIT_W  load value; digit i occupies bits [i*DIGIT_W +: DIGIT_W]; digit 0 is least significant.
- en  in  1  count enable.
- up_dn  in  1  direction: 1 = up, 0 = down.
- cnt  out  DIGITS*DIGIT_W  current count, registered, same packing as load_val.
- digit_tc  out  DIGITS  per-digit terminal flag (combinational from cnt and up_dn).
- cout  out  1  chain carry/borrow (combinational).
- wrapped  out  1  registered one-cycle pulse after a full-chain rollover.

Behaviour:
- Reset (async, any time, including mid-count or mid-load):
  - cnt = 0 for all digits.
  - wrapped = 0.
  - Outputs hold these values while reset is high.
  - First count edge is the first rising clk after reset deasserts.
- Priority at each rising edge: clr > load > en. With none of them asserted, cnt holds.
- clr: all digits = 0; wrapped = 0.
- load:
  - Digit i = load_val digit i.
  - Any loaded digit >= MODULUS is clamped to MODULUS-1.
  - wrapped = 0.
- Terminal value per digit: MODULUS-1 when up_dn=1; 0 when up_dn=0.
  - digit_tc[i] = (digit i == terminal value).
- Digit i steps on an edge when en=1 and digit_tc[j]=1 for all j<i. Digit 0 steps whenever en=1.
- Step rules:
  - Up: MODULUS-1 -> 0, otherwise +1.
  - Down: 0 -> MODULUS-1, otherwise -1.
  - Arithmetic is modulo MODULUS per digit; no digit ever holds a value >= MODULUS after reset, clr or load.
- cout = en & AND(digit_tc). Unlike the decade counter, cout is gated by en so that cascaded chains only step when this chain rolls over. cout is combinational; downstream chains use it as their en.
- wrapped: set to 1 for exactly one cycle on the edge after an edge where cout=1 and neither clr nor load was asserted. Otherwise 0.
- up_dn may change on any cycle:
  - The new direction applies to that same edge's step.
  - digit_tc and cout re-evaluate combinationally.
  - No extra latency and no lost count.
- Latency: cnt updates on the edge where en/clr/load are sampled. wrapped lags rollover by 0 cycles relative to the cnt update, i.e. it is high in the cycle cnt shows the wrapped value.
- Carry path is a combinational ripple across digits. DIGITS <= 8 bounds timing; no pipelining.

Decomposition:
- Shared package: none required. A counter_pkg holding the legal-range checks for MODULUS and DIGIT_W is acceptable if other counters reuse them.
- One natural sub-module: mod_digit.
  - Parameters: DIGIT_W, MODULUS.
  - Ports: clk, reset, clr, load, load_val, step, up_dn, q, tc.
  - Instantiated DIGITS times in a generate loop.
- The top level holds the carry AND-chain, the cout logic and the wrapped register.

Test Plan (DIGITS=4, MODULUS=10, DIGIT_W=4 unless stated):
- Reset mid-count:
  - Stimulus: count up to 0x0357, assert reset asynchronously between edges.
  - Response: cnt=0x0000 and wrapped=0 immediately; on release with en=1, 0x0001 after the first edge.
- Up rollover:
  - Stimulus: load 0x9998, en=1, up_dn=1, two edges.
  - Response: 0x9999 with cout=1, then 0x0000 with wrapped=1 for one cycle; wrapped=0 on the next edge.
- Down borrow:
  - Stimulus: load 0x1000, up_dn=0, one edge.
  - Response: cnt=0x0999.
  - Stimulus: load 0x0000, one edge.
  - Response: cnt=0x9999, wrapped=1.
- Load clamp:
  - Stimulus: load 0xFA3C.
  - Response: cnt=0x9939.
- Priority:
  - Stimulus: clr=1, load=1, en=1 on the same edge from 0x4321.
  - Response: 0x0000.
  - Stimulus: load=1, en=1 with load_val=0x0005.
  - Response: 0x0005, not 0x0006.
- Enable gating and direction flip:
  - Stimulus: at 0x0009 with en=0.
  - Response: cout=0 even though digit 0 is terminal; cnt holds.
  - Stimulus: flip up_dn 1->0 at 0x0010, en=1.
  - Response: 0x0009 after one edge.
  - Stimulus: MODULUS=16 build.
  - Response: 0xFFFF -> 0x0000 rollover.
